div32_seq: RTL and testbench

- Multicycle 32-bit integer divider/remainder unit for the RV32M DIV, DIVU, REM and REMU instructions.
- Performs the inverse of the add32 datapath using restoring division: one trial subtraction per clock.
- Sits beside the ALU. The control unit stalls the uniciclo core while busy is high and writes Q to the register file on done.

---
 rtl/div_pkg.sv | 32 +++
 rtl/div_step.sv | 25 ++
 rtl/div32_seq.sv | 169 ++++++++++++++++
 tb/tb_div32_seq.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the sequential RV32M divider.
package div_pkg;

    localparam int unsigned XLEN = 32;

    // Encoding follows funct3[1:0] of the M-extension divide group.
    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } state_e;

    localparam logic [XLEN-1:0] DIV0_QUO = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    function automatic logic op_is_signed(input op_e op);
        return ~op[0];
    endfunction

    function automatic logic op_is_rem(input op_e op);
        return op[1];
    endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift, trial subtract, set quotient bit.
module div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH-1:0] rem_sh;
    logic [WIDTH:0]   diff;
    logic             ge;

    // The bit shifted out of rem counts as a 2^WIDTH carry, so it forces the subtract.
    always_comb begin
        rem_sh   = {rem[WIDTH-2:0], quo[WIDTH-1]};
        diff     = {1'b0, rem_sh} - {1'b0, divisor};
        ge       = rem[WIDTH-1] | ~diff[WIDTH];
        rem_next = ge ? diff[WIDTH-1:0] : rem_sh;
        quo_next = {quo[WIDTH-2:0], ge};
    end

endmodule

// File: rtl/div32_seq.sv
// Multicycle DIV/DIVU/REM/REMU unit: one restoring step per clock, signs fixed up at the end.
module div32_seq
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = XLEN
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Q
);

    localparam int unsigned   CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic             div0_q, div0_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] divisor_q, divisor_d;
    logic [WIDTH-1:0] q_d;
    logic             busy_d, done_d;

    logic [WIDTH-1:0] step_rem, step_quo;
    logic             sgn, sa, sb;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic [WIDTH-1:0] result;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem_q),
        .quo      (quo_q),
        .divisor  (divisor_q),
        .rem_next (step_rem),
        .quo_next (step_quo)
    );

    // Operand conditioning for the request currently on the inputs.
    always_comb begin
        sgn   = op_is_signed(op_e'(op));
        sa    = sgn & A[WIDTH-1];
        sb    = sgn & B[WIDTH-1];
        abs_a = sa ? (WIDTH'(0) - A) : A;
        abs_b = sb ? (WIDTH'(0) - B) : B;
    end

    // Result selection; for special cases quo_q holds the raw dividend.
    always_comb begin
        if (div0_q) begin
            result = op_is_rem(op_q) ? quo_q : ALL_ONES;
        end else if (ovf_q) begin
            result = op_is_rem(op_q) ? WIDTH'(0) : MIN_NEG;
        end else if (op_is_rem(op_q)) begin
            result = neg_rem_q ? (WIDTH'(0) - rem_q) : rem_q;
        end else begin
            result = neg_quo_q ? (WIDTH'(0) - quo_q) : quo_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, datapath updates and registered-output inputs.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;
        ovf_d     = ovf_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        divisor_d = divisor_q;
        q_d       = Q;
        busy_d    = 1'b0;
        done_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    op_d      = op_e'(op);
                    neg_quo_d = sa ^ sb;
                    neg_rem_d = sa;
                    div0_d    = (B == WIDTH'(0));
                    ovf_d     = sgn && (A == MIN_NEG) && (B == ALL_ONES);
                    divisor_d = abs_b;
                    rem_d     = WIDTH'(0);
                    cnt_d     = CNT_W'(0);
                    if (div0_d || ovf_d) begin
                        quo_d   = A;
                        state_d = FIX;
                    end else begin
                        quo_d   = abs_a;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                q_d     = result;
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == CALC) || (state_d == FIX);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q      <= DIV;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            ovf_q     <= 1'b0;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            divisor_q <= '0;
            Q         <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            op_q      <= op_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
            ovf_q     <= ovf_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            divisor_q <= divisor_d;
            Q         <= q_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

endmodule

// File: tb/tb_div32_seq.sv
// Scoreboard bench for div32_seq: driver queues expected results, monitor checks them on done.
module tb_div32_seq;
    import div_pkg::*;

    localparam int unsigned W = XLEN;
    localparam int LAT_NORM = 34;
    localparam int LAT_SPEC = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] A, B;
    logic         busy, done;
    logic [W-1:0] Q;

    typedef struct {
        string        name;
        logic [W-1:0] q;
        int           lat;
        int           issue;
    } exp_t;

    exp_t         sb[$];
    int           cyc = 0;
    int           n_checks = 0;
    int           n_pass = 0;
    logic [W-1:0] last_q = '0;

    div32_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .Q     (Q)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // Monitor: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && done === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_q"}, Q, e.q);
                check({e.name, "_lat"}, W'(cyc - e.issue), W'(e.lat));
            end
        end
    end

    // Drive one request at a falling edge; optionally register its expected result.
    task automatic issue(input string name, input op_e o, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] exp_q,
                         input int lat, input bit push);
        exp_t e;
        op    = o;
        A     = a;
        B     = b;
        start = 1'b1;
        if (push) begin
            e.name  = name;
            e.q     = exp_q;
            e.lat   = lat;
            e.issue = cyc;
            sb.push_back(e);
            last_q  = exp_q;
        end
        @(negedge clk);
        start = 1'b0;
        A     = W'($urandom);
        B     = W'($urandom);
        op    = 2'($urandom);
        check({name, "_busy"}, W'(busy), W'(1));
    endtask

    task automatic wait_drain();
        int t = 0;
        while (sb.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) check("drain_timeout", W'(sb.size()), W'(0));
        @(negedge clk);
    endtask

    task automatic run(input string name, input op_e o, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] exp_q, input int lat);
        issue(name, o, a, b, exp_q, lat, 1'b1);
        wait_drain();
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        op    = 2'b00;
        A     = '0;
        B     = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", W'(busy), W'(0));
        check("rst_done", W'(done), W'(0));
        check("rst_q", Q, W'(0));
        rst_n = 1'b1;
        @(negedge clk);

        run("divu_100_7",   DIVU, 32'd100,      32'd7,        32'h0000000E, LAT_NORM);
        run("remu_100_7",   REMU, 32'd100,      32'd7,        32'h00000002, LAT_NORM);
        run("div_m7_2",     DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, LAT_NORM);
        run("rem_m7_2",     REM,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, LAT_NORM);
        run("divu_max_max", DIVU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, LAT_NORM);
        run("div_m100_m7",  DIV,  32'hFFFFFF9C, 32'hFFFFFFF9, 32'h0000000E, LAT_NORM);
        run("rem_m100_m7",  REM,  32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, LAT_NORM);
        run("div_100_m7",   DIV,  32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, LAT_NORM);
        run("rem_100_m7",   REM,  32'd100,      32'hFFFFFFF9, 32'h00000002, LAT_NORM);
        run("div_min_1",    DIV,  INT_MIN,      32'd1,        INT_MIN,      LAT_NORM);
        run("remu_min_max", REMU, INT_MIN,      32'hFFFFFFFF, INT_MIN,      LAT_NORM);
        run("divu_max_1",   DIVU, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, LAT_NORM);

        run("divu_5_0",     DIVU, 32'd5,        32'd0,        DIV0_QUO,     LAT_SPEC);
        run("remu_5_0",     REMU, 32'd5,        32'd0,        32'h00000005, LAT_SPEC);
        run("div_m5_0",     DIV,  32'hFFFFFFFB, 32'd0,        DIV0_QUO,     LAT_SPEC);
        run("rem_m5_0",     REM,  32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, LAT_SPEC);
        run("div_ovf",      DIV,  INT_MIN,      32'hFFFFFFFF, INT_MIN,      LAT_SPEC);
        run("rem_ovf",      REM,  INT_MIN,      32'hFFFFFFFF, 32'h00000000, LAT_SPEC);

        // A start while busy must be dropped, not queued.
        issue("divu_ign", DIVU, 32'd100, 32'd7, 32'h0000000E, LAT_NORM, 1'b1);
        repeat (3) @(negedge clk);
        issue("ign_pulse", DIVU, 32'd5, 32'd0, 32'h0, 0, 1'b0);
        wait_drain();
        repeat (10) @(negedge clk);
        check("q_hold_idle", Q, last_q);
        check("idle_busy", W'(busy), W'(0));

        // Reset mid-operation aborts silently and clears Q.
        issue("divu_abort", DIVU, 32'd100, 32'd7, 32'h0, 0, 1'b0);
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_busy", W'(busy), W'(0));
        check("abort_done", W'(done), W'(0));
        check("abort_q", Q, W'(0));
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("abort_q_hold", Q, W'(0));

        run("divu_after_rst", DIVU, 32'd100, 32'd7, 32'h0000000E, LAT_NORM);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
